// File: rtl/debounce16.sv
// Sixteen independent switch debouncers: 2-flop synchroniser plus a stability
// counter per lane, with a single registered "any lane changed" pulse.

module debounce16_lane #(
    parameter int           CW      = 1,
    parameter logic [CW-1:0] CNT_MAX = '0,
    parameter logic          RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic a_i,
    output logic q_o,
    output logic accept_o
);

    logic          s1_q;
    logic          s2_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;

    // Any cycle where s2 agrees with the output clears the count, so a bounce
    // back to the old level always restarts the stability window.
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        accept = 1'b0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                accept = 1'b1;
                lvl_d  = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            lvl_q <= RST_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= a_i;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o      = lvl_q;
    assign accept_o = accept;

endmodule

module debounce16 #(
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] RESET_VAL       = 16'h0000
) (
    input  logic CLK,
    input  logic RST,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic A6,
    input  logic A7,
    input  logic A8,
    input  logic A9,
    input  logic A10,
    input  logic A11,
    input  logic A12,
    input  logic A13,
    input  logic A14,
    input  logic A15,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic Q4,
    output logic Q5,
    output logic Q6,
    output logic Q7,
    output logic Q8,
    output logic Q9,
    output logic Q10,
    output logic Q11,
    output logic Q12,
    output logic Q13,
    output logic Q14,
    output logic Q15,
    output logic CHG
);

    localparam int          CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0] a_vec;
    logic [15:0] q_vec;
    logic [15:0] accept_vec;
    logic        chg_q;
    logic        chg_d;

    assign a_vec = {A15, A14, A13, A12, A11, A10, A9, A8,
                    A7,  A6,  A5,  A4,  A3,  A2,  A1, A0};

    for (genvar i = 0; i < 16; i++) begin : g_lane
        debounce16_lane #(
            .CW      (CW),
            .CNT_MAX (CNT_MAX),
            .RST_VAL (RESET_VAL[i])
        ) u_lane (
            .clk_i    (CLK),
            .rst_i    (RST),
            .a_i      (a_vec[i]),
            .q_o      (q_vec[i]),
            .accept_o (accept_vec[i])
        );
    end

    assign chg_d = |accept_vec;

    always_ff @(posedge CLK) begin
        if (RST) chg_q <= 1'b0;
        else     chg_q <= chg_d;
    end

    assign {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8,
            Q7,  Q6,  Q5,  Q4,  Q3,  Q2,  Q1, Q0} = q_vec;
    assign CHG = chg_q;

endmodule

// File: tb/tb_debounce16.sv
// Directed bench for debounce16: two instances (N=4/reset 0, N=1/reset all ones)
// checked cycle by cycle against a queue of expected outputs.

module tb_debounce16;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '1;
    logic [15:0] qa;
    logic [15:0] qb;
    logic        chga;
    logic        chgb;

    int vectors = 0;
    int fails   = 0;

    typedef struct packed {
        logic        sel;
        logic [15:0] q;
        logic        chg;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    debounce16 #(.DEBOUNCE_CYCLES(4), .RESET_VAL(16'h0000)) u_dut_a (
        .CLK(clk), .RST(rst_a),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
        .A8(a[8]), .A9(a[9]), .A10(a[10]), .A11(a[11]), .A12(a[12]), .A13(a[13]), .A14(a[14]), .A15(a[15]),
        .Q0(qa[0]), .Q1(qa[1]), .Q2(qa[2]), .Q3(qa[3]), .Q4(qa[4]), .Q5(qa[5]), .Q6(qa[6]), .Q7(qa[7]),
        .Q8(qa[8]), .Q9(qa[9]), .Q10(qa[10]), .Q11(qa[11]), .Q12(qa[12]), .Q13(qa[13]), .Q14(qa[14]), .Q15(qa[15]),
        .CHG(chga)
    );

    debounce16 #(.DEBOUNCE_CYCLES(1), .RESET_VAL(16'hFFFF)) u_dut_b (
        .CLK(clk), .RST(rst_b),
        .A0(b[0]), .A1(b[1]), .A2(b[2]), .A3(b[3]), .A4(b[4]), .A5(b[5]), .A6(b[6]), .A7(b[7]),
        .A8(b[8]), .A9(b[9]), .A10(b[10]), .A11(b[11]), .A12(b[12]), .A13(b[13]), .A14(b[14]), .A15(b[15]),
        .Q0(qb[0]), .Q1(qb[1]), .Q2(qb[2]), .Q3(qb[3]), .Q4(qb[4]), .Q5(qb[5]), .Q6(qb[6]), .Q7(qb[7]),
        .Q8(qb[8]), .Q9(qb[9]), .Q10(qb[10]), .Q11(qb[11]), .Q12(qb[12]), .Q13(qb[13]), .Q14(qb[14]), .Q15(qb[15]),
        .CHG(chgb)
    );

    // Push the expectation for the next edge, advance one edge, then compare.
    task automatic step(input logic sel, input logic [15:0] q, input logic chg, input string tag);
        exp_t        e;
        logic [15:0] obs_q;
        logic        obs_c;
        sb.push_back('{sel: sel, q: q, chg: chg});
        @(posedge clk);
        #1;
        e     = sb.pop_front();
        obs_q = e.sel ? qb : qa;
        obs_c = e.sel ? chgb : chga;
        vectors++;
        assert (obs_q === e.q) else begin
            fails++;
            $error("FAIL %s q observed=%h expected=%h", tag, obs_q, e.q);
        end
        vectors++;
        assert (obs_c === e.chg) else begin
            fails++;
            $error("FAIL %s chg observed=%b expected=%b", tag, obs_c, e.chg);
        end
    endtask

    task automatic steps(input int n, input logic sel, input logic [15:0] q, input logic chg, input string tag);
        for (int i = 0; i < n; i++) step(sel, q, chg, tag);
    endtask

    initial begin
        // 1) reset state and basic N=4 latency (edge 6)
        rst_a = 1'b1;
        steps(2, 0, 16'h0000, 1'b0, "reset_a");
        rst_a = 1'b0;
        steps(3, 0, 16'h0000, 1'b0, "idle_a");
        a[3] = 1'b1;
        steps(5, 0, 16'h0000, 1'b0, "a3_wait");
        step(0, 16'h0008, 1'b1, "a3_accept");
        steps(3, 0, 16'h0008, 1'b0, "a3_hold");

        // 2) 3-cycle pulse is rejected
        a[5] = 1'b1;
        steps(3, 0, 16'h0008, 1'b0, "a5_pulse");
        a[5] = 1'b0;
        steps(6, 0, 16'h0008, 1'b0, "a5_reject");

        // 3) bounce on A7, then a stable rise
        for (int k = 0; k < 5; k++) begin
            a[7] = 1'b0;
            steps(2, 0, 16'h0008, 1'b0, "a7_bounce_lo");
            a[7] = 1'b1;
            steps(2, 0, 16'h0008, 1'b0, "a7_bounce_hi");
        end
        a[7] = 1'b0;
        steps(2, 0, 16'h0008, 1'b0, "a7_bounce_lo");
        a[7] = 1'b1;
        steps(5, 0, 16'h0008, 1'b0, "a7_wait");
        step(0, 16'h0088, 1'b1, "a7_accept");
        steps(2, 0, 16'h0088, 1'b0, "a7_hold");

        // 4) two lanes accept on the same edge -> one pulse
        a[0]  = 1'b1;
        a[15] = 1'b1;
        steps(5, 0, 16'h0088, 1'b0, "a0_a15_wait");
        step(0, 16'h8089, 1'b1, "a0_a15_accept");
        steps(2, 0, 16'h8089, 1'b0, "a0_a15_hold");

        // 5) reset mid-count discards progress; all still-high lanes re-accept together
        a[2] = 1'b1;
        steps(4, 0, 16'h8089, 1'b0, "a2_count");
        rst_a = 1'b1;
        step(0, 16'h0000, 1'b0, "a2_reset");
        rst_a = 1'b0;
        steps(5, 0, 16'h0000, 1'b0, "post_reset_wait");
        step(0, 16'h808D, 1'b1, "post_reset_accept");
        steps(2, 0, 16'h808D, 1'b0, "post_reset_hold");

        // 6) N=1, reset value all ones
        rst_b = 1'b1;
        steps(2, 1, 16'hFFFF, 1'b0, "reset_b");
        rst_b = 1'b0;
        steps(3, 1, 16'hFFFF, 1'b0, "idle_b");
        b[9] = 1'b0;
        steps(2, 1, 16'hFFFF, 1'b0, "b9_wait");
        step(1, 16'hFDFF, 1'b1, "b9_accept");
        steps(2, 1, 16'hFDFF, 1'b0, "b9_hold");
        // back-to-back acceptances on consecutive edges keep CHG high
        b[9] = 1'b1;
        step(1, 16'hFDFF, 1'b0, "b9_rise_s1");
        b[1] = 1'b0;
        step(1, 16'hFDFF, 1'b0, "b9_rise_s2");
        step(1, 16'hFFFF, 1'b1, "b9_reaccept");
        step(1, 16'hFFFD, 1'b1, "b1_accept");
        step(1, 16'hFFFD, 1'b0, "b1_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
